// File: rtl/pma_rx.sv
// rtl/pma_rx.sv - PMA receive stage: NRZI to NRZ decode and link monitor
module pma_rx #(
  parameter int STABILIZE_CYCLES = 50000,
  parameter int FAIL_COUNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  nrzi,
  input  logic [1:0]                  nrzi_valid,
  input  logic                        signal_status,
  output logic [1:0]                  bits,
  output logic [1:0]                  bits_valid,
  output logic                        link_status,
  output logic [FAIL_COUNT_WIDTH-1:0] link_fail_count
);

  localparam int TW = $clog2(STABILIZE_CYCLES);
  localparam logic [TW-1:0] TERM = TW'(STABILIZE_CYCLES - 1);

  typedef enum logic [1:0] {ST_FAIL, ST_HYST, ST_OK} state_t;

  logic          last;
  logic          sync1;
  logic          sig_s;
  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic [TW-1:0] next_timer;

  // NRZI decode: each bit is a transition relative to the previous line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= 1'b0;
      bits       <= 2'b11;
      bits_valid <= 2'd0;
    end else begin
      bits_valid <= (nrzi_valid == 2'd3) ? 2'd2 : nrzi_valid;
      case (nrzi_valid)
        2'd1: begin
          bits <= {nrzi[1] ^ last, 1'b1};
          last <= nrzi[1];
        end
        2'd2, 2'd3: begin
          bits <= {nrzi[1] ^ last, nrzi[0] ^ nrzi[1]};
          last <= nrzi[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (nrzi_valid != 2'd3)
        else $error("pma_rx: nrzi_valid=3 is illegal, decoded as 2");
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sig_s <= 1'b0;
    end else begin
      sync1 <= signal_status;
      sig_s <= sync1;
    end
  end

  // A drop of sig_s always wins over the terminal count
  always_comb begin
    next_state = state;
    next_timer = timer;
    case (state)
      ST_FAIL: begin
        next_timer = '0;
        if (sig_s) next_state = ST_HYST;
      end
      ST_HYST: begin
        if (!sig_s) begin
          next_state = ST_FAIL;
          next_timer = '0;
        end else if (timer == TERM) begin
          next_state = ST_OK;
          next_timer = '0;
        end else begin
          next_timer = timer + TW'(1);
        end
      end
      ST_OK: begin
        next_timer = '0;
        if (!sig_s) next_state = ST_FAIL;
      end
      default: begin
        next_state = ST_FAIL;
        next_timer = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_FAIL;
      timer           <= '0;
      link_status     <= 1'b0;
      link_fail_count <= '0;
    end else begin
      state       <= next_state;
      timer       <= next_timer;
      link_status <= (next_state == ST_OK);
      if (state == ST_OK && next_state == ST_FAIL && link_fail_count != '1)
        link_fail_count <= link_fail_count + FAIL_COUNT_WIDTH'(1);
    end
  end

endmodule
